// File: rtl/sniff_scheduler.sv
// BLE advertising-channel hop controller for a single packet-sniffer datapath.
// Sequences TUNE/LISTEN windows per channel and captures detected packets.
module sniff_scheduler #(
    parameter logic [23:0] DWELL_CYCLES  = 24'd100000,
    parameter int          SETTLE_CYCLES = 4,
    parameter logic [5:0]  CH_FIRST      = 6'd37,
    parameter logic [5:0]  CH_LAST       = 6'd39
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        stop,
    input  logic        packet_detected,
    input  logic [8:0]  packet_len,
    output logic        sniffer_en,
    output logic [5:0]  channel,
    output logic        busy,
    output logic        pkt_valid,
    input  logic        pkt_ready,
    output logic [5:0]  pkt_channel,
    output logic [8:0]  pkt_len,
    output logic [15:0] hop_count,
    output logic [7:0]  drop_count
);

    typedef enum logic [1:0] {
        IDLE,
        TUNE,
        LISTEN
    } state_t;

    localparam logic [7:0]  SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
    localparam logic [23:0] DWELL_LAST  = DWELL_CYCLES - 24'd1;

    state_t      state;
    logic [7:0]  settle_cnt;
    logic [23:0] dwell_cnt;

    logic       capture_ev;
    logic       take;
    logic       drop;
    logic       expiry;
    logic [5:0] next_ch;

    always_comb begin
        capture_ev = (state == LISTEN) && packet_detected;
        take       = capture_ev && (!pkt_valid || pkt_ready);
        drop       = capture_ev && pkt_valid && !pkt_ready;
        expiry     = (state == LISTEN) && (dwell_cnt == DWELL_LAST);
        next_ch    = (channel == CH_LAST) ? CH_FIRST : channel + 6'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            settle_cnt  <= 8'd0;
            dwell_cnt   <= 24'd0;
            sniffer_en  <= 1'b0;
            channel     <= CH_FIRST;
            busy        <= 1'b0;
            pkt_valid   <= 1'b0;
            pkt_channel <= 6'd0;
            pkt_len     <= 9'd0;
            hop_count   <= 16'd0;
            drop_count  <= 8'd0;
        end else begin
            if (pkt_valid && pkt_ready) begin
                pkt_valid <= 1'b0;
            end
            if (take) begin
                pkt_valid   <= 1'b1;
                pkt_channel <= channel;
                pkt_len     <= packet_len;
            end
            if (drop && (drop_count != 8'hFF)) begin
                drop_count <= drop_count + 8'd1;
            end

            if (stop) begin
                state      <= IDLE;
                sniffer_en <= 1'b0;
                busy       <= 1'b0;
                settle_cnt <= 8'd0;
                dwell_cnt  <= 24'd0;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (start) begin
                            state      <= TUNE;
                            busy       <= 1'b1;
                            channel    <= CH_FIRST;
                            settle_cnt <= 8'd0;
                            dwell_cnt  <= 24'd0;
                        end
                    end
                    TUNE: begin
                        if (settle_cnt == SETTLE_LAST) begin
                            state      <= LISTEN;
                            sniffer_en <= 1'b1;
                            settle_cnt <= 8'd0;
                        end else begin
                            settle_cnt <= settle_cnt + 8'd1;
                        end
                    end
                    LISTEN: begin
                        // A capture cycle still counts toward the dwell budget
                        if (expiry) begin
                            state      <= TUNE;
                            sniffer_en <= 1'b0;
                            channel    <= next_ch;
                            dwell_cnt  <= 24'd0;
                            hop_count  <= hop_count + 16'd1;
                        end else begin
                            dwell_cnt <= dwell_cnt + 24'd1;
                            if (capture_ev) begin
                                state      <= TUNE;
                                sniffer_en <= 1'b0;
                            end
                        end
                    end
                    default: begin
                        state      <= IDLE;
                        sniffer_en <= 1'b0;
                        busy       <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sniff_scheduler.sv
// Testbench for sniff_scheduler: directed vector table, corner sequences,
// and randomized traffic against a remaining-time reference model.
module tb_sniff_scheduler;

    localparam int D = 10;
    localparam int S = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        stop;
    logic        packet_detected;
    logic [8:0]  packet_len;
    logic        sniffer_en;
    logic [5:0]  channel;
    logic        busy;
    logic        pkt_valid;
    logic        pkt_ready;
    logic [5:0]  pkt_channel;
    logic [8:0]  pkt_len;
    logic [15:0] hop_count;
    logic [7:0]  drop_count;

    always #5 clk = ~clk;

    sniff_scheduler #(
        .DWELL_CYCLES (24'd10),
        .SETTLE_CYCLES(2),
        .CH_FIRST     (6'd37),
        .CH_LAST      (6'd39)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .stop           (stop),
        .packet_detected(packet_detected),
        .packet_len     (packet_len),
        .sniffer_en     (sniffer_en),
        .channel        (channel),
        .busy           (busy),
        .pkt_valid      (pkt_valid),
        .pkt_ready      (pkt_ready),
        .pkt_channel    (pkt_channel),
        .pkt_len        (pkt_len),
        .hop_count      (hop_count),
        .drop_count     (drop_count)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %0d required %0d", nm, act, exp);
        end
    endtask

    // Reference model: mode 0 idle, 1 settling, 2 listening; time kept as
    // cycles remaining in the settle window and in the channel's dwell budget.
    int m_mode, m_settle_left, m_dwell_left;
    int m_ch, m_hop, m_drop, m_valid, m_len, m_pch;

    task automatic model_reset();
        m_mode = 0; m_settle_left = 0; m_dwell_left = D;
        m_ch = 37; m_hop = 0; m_drop = 0;
        m_valid = 0; m_len = 0; m_pch = 0;
    endtask

    task automatic model_step();
        bit cap;
        int v0;
        cap = (m_mode == 2) && packet_detected;
        v0 = m_valid;
        if (v0 != 0 && pkt_ready) m_valid = 0;
        if (cap) begin
            if (v0 == 0 || pkt_ready) begin
                m_valid = 1; m_len = packet_len; m_pch = m_ch;
            end else if (m_drop < 255) begin
                m_drop++;
            end
        end
        if (stop) begin
            m_mode = 0;
        end else if (m_mode == 0) begin
            if (start) begin
                m_mode = 1; m_settle_left = S; m_dwell_left = D; m_ch = 37;
            end
        end else if (m_mode == 1) begin
            m_settle_left--;
            if (m_settle_left == 0) m_mode = 2;
        end else begin
            m_dwell_left--;
            if (m_dwell_left == 0) begin
                m_ch = (m_ch == 39) ? 37 : m_ch + 1;
                m_hop = (m_hop + 1) % 65536;
                m_dwell_left = D;
                m_mode = 1; m_settle_left = S;
            end else if (cap) begin
                m_mode = 1; m_settle_left = S;
            end
        end
    endtask

    task automatic check_model();
        chk("model_en", sniffer_en, (m_mode == 2));
        chk("model_busy", busy, (m_mode != 0));
        chk("model_ch", channel, m_ch);
        chk("model_valid", pkt_valid, m_valid);
        chk("model_len", pkt_len, m_len);
        chk("model_pch", pkt_channel, m_pch);
        chk("model_hop", hop_count, m_hop);
        chk("model_drop", drop_count, m_drop);
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        check_model();
    endtask

    task automatic clear_inputs();
        start = 0; stop = 0; packet_detected = 0;
        packet_len = 0; pkt_ready = 0;
    endtask

    task automatic do_reset();
        #1 rst = 1;
        model_reset();
        #1;
        chk("rst_en", sniffer_en, 0);
        chk("rst_ch", channel, 37);
        chk("rst_busy", busy, 0);
        chk("rst_valid", pkt_valid, 0);
        chk("rst_hop", hop_count, 0);
        chk("rst_drop", drop_count, 0);
        @(posedge clk);
        #1 rst = 0;
    endtask

    typedef struct {
        int reps;
        bit st, sp, pd;
        int len;
        bit rdy;
        int en, ch, bz, vl, pl, pc, hop, drp;
    } row_t;

    row_t tbl[22];
    int   nrow = 0;

    task automatic add(input int reps, input bit st, input bit sp,
                       input bit pd, input int len, input bit rdy,
                       input int en, input int ch, input int bz,
                       input int vl, input int pl, input int pc,
                       input int hop, input int drp);
        tbl[nrow] = '{reps, st, sp, pd, len, rdy,
                      en, ch, bz, vl, pl, pc, hop, drp};
        nrow++;
    endtask

    initial begin
        rst = 1;
        clear_inputs();
        model_reset();
        #2;
        chk("init_ch", channel, 37);
        chk("init_en", sniffer_en, 0);
        @(posedge clk);
        #1 rst = 0;

        //  reps st sp pd len rdy | en ch bz vl len pch hop drop
        add(1, 1, 0, 0,   0, 0,   0, 37, 1, 0,   0,  0, 0, 0);
        add(2, 0, 0, 0,   0, 0,   1, 37, 1, 0,   0,  0, 0, 0);
        add(9, 0, 0, 0,   0, 0,   1, 37, 1, 0,   0,  0, 0, 0);
        add(1, 0, 0, 0,   0, 0,   0, 38, 1, 0,   0,  0, 1, 0);
        add(2, 0, 0, 0,   0, 0,   1, 38, 1, 0,   0,  0, 1, 0);
        add(1, 0, 0, 1, 120, 0,   0, 38, 1, 1, 120, 38, 1, 0);
        add(2, 0, 0, 0,   0, 0,   1, 38, 1, 1, 120, 38, 1, 0);
        add(8, 0, 0, 0,   0, 0,   1, 38, 1, 1, 120, 38, 1, 0);
        add(1, 0, 0, 0,   0, 0,   0, 39, 1, 1, 120, 38, 2, 0);
        add(2, 0, 0, 0,   0, 0,   1, 39, 1, 1, 120, 38, 2, 0);
        add(1, 0, 0, 1,  50, 0,   0, 39, 1, 1, 120, 38, 2, 1);
        add(2, 0, 0, 0,   0, 0,   1, 39, 1, 1, 120, 38, 2, 1);
        add(1, 0, 0, 1,  77, 1,   0, 39, 1, 1,  77, 39, 2, 1);
        add(2, 0, 0, 0,   0, 0,   1, 39, 1, 1,  77, 39, 2, 1);
        add(7, 0, 0, 0,   0, 0,   1, 39, 1, 1,  77, 39, 2, 1);
        add(1, 0, 0, 1, 200, 1,   0, 37, 1, 1, 200, 39, 3, 1);
        add(1, 0, 0, 0,   0, 1,   0, 37, 1, 0, 200, 39, 3, 1);
        add(1, 0, 0, 0,   0, 0,   1, 37, 1, 0, 200, 39, 3, 1);
        add(1, 0, 0, 1,   5, 0,   0, 37, 1, 1,   5, 37, 3, 1);
        add(2, 0, 0, 0,   0, 0,   1, 37, 1, 1,   5, 37, 3, 1);
        add(1, 0, 1, 0,   0, 0,   0, 37, 0, 1,   5, 37, 3, 1);
        add(1, 1, 1, 0,   0, 0,   0, 37, 0, 1,   5, 37, 3, 1);

        for (int r = 0; r < nrow; r++) begin
            start = tbl[r].st; stop = tbl[r].sp;
            packet_detected = tbl[r].pd;
            packet_len = 9'(tbl[r].len); pkt_ready = tbl[r].rdy;
            for (int k = 0; k < tbl[r].reps; k++) tick();
            clear_inputs();
            chk($sformatf("row%0d_en", r), sniffer_en, tbl[r].en);
            chk($sformatf("row%0d_ch", r), channel, tbl[r].ch);
            chk($sformatf("row%0d_busy", r), busy, tbl[r].bz);
            chk($sformatf("row%0d_valid", r), pkt_valid, tbl[r].vl);
            chk($sformatf("row%0d_len", r), pkt_len, tbl[r].pl);
            chk($sformatf("row%0d_pch", r), pkt_channel, tbl[r].pc);
            chk($sformatf("row%0d_hop", r), hop_count, tbl[r].hop);
            chk($sformatf("row%0d_drop", r), drop_count, tbl[r].drp);
        end

        // Asynchronous reset asserted mid-settle
        start = 1; tick(); clear_inputs(); tick();
        chk("pre_rst_busy", busy, 1);
        #2 rst = 1;
        #1;
        chk("arst_en", sniffer_en, 0);
        chk("arst_busy", busy, 0);
        chk("arst_ch", channel, 37);
        chk("arst_valid", pkt_valid, 0);
        chk("arst_len", pkt_len, 0);
        chk("arst_pch", pkt_channel, 0);
        chk("arst_hop", hop_count, 0);
        chk("arst_drop", drop_count, 0);
        model_reset();
        @(posedge clk);
        #1 rst = 0;

        // Drop counter saturation under continuous unconsumed traffic
        start = 1; tick(); clear_inputs();
        packet_detected = 1; packet_len = 9'd33;
        for (int k = 0; k < 1100; k++) tick();
        clear_inputs();
        chk("drop_saturated", drop_count, 255);
        chk("sat_len_kept", pkt_len, 33);

        // Randomized traffic against the model
        do_reset();
        for (int k = 0; k < 4000; k++) begin
            start = ($urandom % 12) == 0;
            stop = ($urandom % 150) == 0;
            packet_detected = ($urandom % 6) == 0;
            packet_len = 9'($urandom);
            pkt_ready = ($urandom % 3) == 0;
            tick();
        end
        clear_inputs();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
